dodge_core: RTL

- Parametrised successor to the 8x8 falling-object dodge game engine.
- Runs N falling objects on a ROWS x COLS grid, plus a player sprite, a lives counter, a dodge score and a game-state machine.
- Runs entirely on CLK, advanced by a one-cycle `tick` enable; there are no divided clocks.
- Sits between the button/tick dividers and the LED matrix scanner. The scanner reads the frame one column at a time through a combinational read port.

---
 rtl/dodge_core.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dodge_core.sv
// Falling-object dodge game engine: NOBJ objects on a ROWS x COLS grid, player sprite, lives, score.
// Optional DODGE_SPEEDUP_EN: a tick divider in PLAY that shortens as the score grows.
module dodge_core #(
    parameter int          ROWS      = 8,
    parameter int          COLS      = 8,
    parameter int          NOBJ      = 3,
    parameter int          LIVES     = 3,
    parameter int          PLAYER_H  = 2,
    parameter int          SPAWN_GAP = 3,
    parameter int          HIT_HOLD  = 4,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          SCORE_W   = 8
) (
    input  logic                    CLK,
    input  logic                    clear,
    input  logic                    tick,
    input  logic                    start,
    input  logic                    left,
    input  logic                    right,
    input  logic [$clog2(COLS)-1:0] scan_col,
    output logic [ROWS-1:0]         obj_bits,
    output logic [ROWS-1:0]         ply_bits,
    output logic [$clog2(COLS)-1:0] player_col,
    output logic [3:0]              lives,
    output logic [SCORE_W-1:0]      score,
    output logic                    hit,
    output logic                    beep,
    output logic                    game_over,
    output logic [1:0]              state
);
    localparam int CW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam int GW = (SPAWN_GAP < 1) ? 1 : $clog2(SPAWN_GAP + 1);
    localparam int HW = $clog2(HIT_HOLD + 1);

    localparam logic [CW-1:0] CENTRE     = CW'(COLS / 2 - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(ROWS - 1);
    localparam logic [YW-1:0] Y_PLY      = YW'(ROWS - PLAYER_H);
    localparam logic [3:0]    LIVES_INIT = 4'(LIVES);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(SPAWN_GAP);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HIT_HOLD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_HIT  = 2'd2,
        S_OVER = 2'd3
    } state_t;

    // Fibonacci LFSR, taps 16,14,13,11, feedback enters bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    state_t             state_q, state_d;
    logic [CW-1:0]      pcol_q, pcol_d;
    logic [3:0]         lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [NOBJ-1:0]    act_q, act_d;
    logic [YW-1:0]      oy_q [NOBJ];
    logic [YW-1:0]      oy_d [NOBJ];
    logic [CW-1:0]      ox_q [NOBJ];
    logic [CW-1:0]      ox_d [NOBJ];
    logic [GW-1:0]      gap_q, gap_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic               hit_q, hit_d;
    logic               beep_q, beep_d;
    logic               step_s, found_s, collide_s;

    always_ff @(posedge CLK) begin
        if (clear) begin
            state_q <= S_IDLE;
            pcol_q  <= CENTRE;
            lives_q <= LIVES_INIT;
            score_q <= '0;
            act_q   <= '0;
            for (int i = 0; i < NOBJ; i++) begin
                oy_q[i] <= '0;
                ox_q[i] <= '0;
            end
            gap_q   <= '0;
            lfsr_q  <= SEED;
            hold_q  <= '0;
            hit_q   <= 1'b0;
            beep_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pcol_q  <= pcol_d;
            lives_q <= lives_d;
            score_q <= score_d;
            act_q   <= act_d;
            oy_q    <= oy_d;
            ox_q    <= ox_d;
            gap_q   <= gap_d;
            lfsr_q  <= lfsr_d;
            hold_q  <= hold_d;
            hit_q   <= hit_d;
            beep_q  <= beep_d;
        end
    end

`ifdef DODGE_SPEEDUP_EN
    logic [2:0] div_q, div_d, dcnt_q, dcnt_d;
    logic       restart_s;

    assign restart_s = tick && start && (state_q == S_IDLE || state_q == S_OVER);

    always_ff @(posedge CLK) begin
        if (clear) begin
            div_q  <= 3'd4;
            dcnt_q <= 3'd0;
        end else begin
            div_q  <= div_d;
            dcnt_q <= dcnt_d;
        end
    end

    // A PLAY step fires on every div-th tick; HIT keeps counting raw ticks.
    always_comb begin
        step_s = 1'b0;
        dcnt_d = dcnt_q;
        if (restart_s) begin
            dcnt_d = 3'd0;
        end else if (state_q == S_PLAY && tick) begin
            if (dcnt_q + 3'd1 >= div_q) begin
                step_s = 1'b1;
                dcnt_d = 3'd0;
            end else begin
                dcnt_d = dcnt_q + 3'd1;
            end
        end else begin
            dcnt_d = dcnt_q;
        end
    end

    always_comb begin
        if (restart_s) begin
            div_d = 3'd4;
        end else if (score_d[SCORE_W-1:3] != score_q[SCORE_W-1:3] && div_q > 3'd1) begin
            div_d = div_q - 3'd1;
        end else begin
            div_d = div_q;
        end
    end
`else
    assign step_s = tick;
`endif

    always_comb begin
        state_d   = state_q;
        pcol_d    = pcol_q;
        lives_d   = lives_q;
        score_d   = score_q;
        act_d     = act_q;
        oy_d      = oy_q;
        ox_d      = ox_q;
        gap_d     = gap_q;
        lfsr_d    = lfsr_q;
        hold_d    = hold_q;
        hit_d     = 1'b0;
        found_s   = 1'b0;
        collide_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick && start) state_d = S_PLAY;
                else               state_d = S_IDLE;
            end
            S_PLAY: begin
                if (step_s) begin
                    if (right && !left && pcol_q != COL_LAST)   pcol_d = pcol_q + 1'b1;
                    else if (left && !right && pcol_q != '0)    pcol_d = pcol_q - 1'b1;
                    else                                        pcol_d = pcol_q;
                    for (int i = 0; i < NOBJ; i++) begin
                        if (act_q[i] && oy_q[i] == Y_LAST) begin
                            act_d[i] = 1'b0;
                            score_d  = score_d + 1'b1;
                        end else if (act_q[i]) begin
                            oy_d[i] = oy_q[i] + 1'b1;
                        end else begin
                            oy_d[i] = oy_q[i];
                        end
                    end
                    // Spawn into the lowest free slot; objects freed this step are eligible.
                    if (gap_q == '0) begin
                        for (int i = 0; i < NOBJ; i++) begin
                            if (!found_s && !act_d[i]) begin
                                act_d[i] = 1'b1;
                                oy_d[i]  = '0;
                                ox_d[i]  = lfsr_q[CW-1:0];
                                found_s  = 1'b1;
                            end else begin
                                found_s  = found_s;
                            end
                        end
                        if (found_s) begin
                            lfsr_d = lfsr_next(lfsr_q);
                            gap_d  = GAP_LOAD;
                        end else begin
                            gap_d  = '0;
                        end
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                    for (int i = 0; i < NOBJ; i++) begin
                        if (act_d[i] && ox_d[i] == pcol_d && oy_d[i] >= Y_PLY) collide_s = 1'b1;
                        else                                                   collide_s = collide_s;
                    end
                    if (collide_s) begin
                        act_d   = '0;
                        gap_d   = GAP_LOAD;
                        lives_d = lives_q - 4'd1;
                        hit_d   = 1'b1;
                        hold_d  = HOLD_LOAD;
                        state_d = (lives_q == 4'd1) ? S_OVER : S_HIT;
                    end else begin
                        state_d = S_PLAY;
                    end
                end else begin
                    state_d = S_PLAY;
                end
            end
            S_HIT: begin
                if (tick && hold_q <= HW'(1)) begin
                    hold_d  = '0;
                    state_d = S_PLAY;
                end else if (tick) begin
                    hold_d  = hold_q - 1'b1;
                    state_d = S_HIT;
                end else begin
                    state_d = S_HIT;
                end
            end
            S_OVER: begin
                if (tick && start) begin
                    state_d = S_PLAY;
                    lives_d = LIVES_INIT;
                    score_d = '0;
                    pcol_d  = CENTRE;
                    act_d   = '0;
                    gap_d   = '0;
                end else begin
                    state_d = S_OVER;
                end
            end
            default: state_d = S_IDLE;
        endcase
        beep_d = (state_d == S_HIT);
    end

    // Combinational column read port for the LED scanner.
    always_comb begin
        obj_bits = '0;
        ply_bits = '0;
        for (int y = 0; y < ROWS; y++) begin
            if (state_q == S_OVER) begin
                obj_bits[y] = (y == int'(scan_col) * ROWS / COLS) ||
                              (y == ROWS - 1 - int'(scan_col) * ROWS / COLS);
            end else begin
                ply_bits[y] = (scan_col == pcol_q) && (y >= ROWS - PLAYER_H);
                for (int i = 0; i < NOBJ; i++) begin
                    if (state_q == S_PLAY && act_q[i] && ox_q[i] == scan_col && int'(oy_q[i]) == y)
                        obj_bits[y] = 1'b1;
                    else
                        obj_bits[y] = obj_bits[y];
                end
            end
        end
    end

    assign player_col = pcol_q;
    assign lives      = lives_q;
    assign score      = score_q;
    assign hit        = hit_q;
    assign beep       = beep_q;
    assign game_over  = (state_q == S_OVER);
    assign state      = state_q;

endmodule
